// File: rtl/vending_machine_ctrl.sv
// Four-drink vending controller: accumulates 1/5/10 coins into credit, dispenses on
// selection when credit covers the price, and returns the whole credit as change on request.
module vending_machine_ctrl #(
  parameter int PRICE1  = 10,
  parameter int PRICE2  = 15,
  parameter int PRICE3  = 20,
  parameter int PRICE4  = 25,
  parameter int MAX_BAL = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] coin,
  input  logic [3:0] drink_choose,
  input  logic       en_machine,
  output logic [7:0] balance,
  output logic       dispense,
  output logic [3:0] drink_out,
  output logic       insufficient,
  output logic       change_valid,
  output logic [7:0] change,
  output logic       coin_reject
);

  typedef struct packed {
    logic [7:0] balance;
    logic       dispense;
    logic [3:0] drink_out;
    logic       insufficient;
    logic       change_valid;
    logic [7:0] change;
    logic       coin_reject;
  } txn_t;

  typedef enum logic {IDLE, CREDIT} state_t;

  state_t     state, state_nxt;
  txn_t       txn;
  logic       coin_ok, accept;
  logic [8:0] sum;
  logic [7:0] b, price;

  // Coin step: accept only legal denominations that keep credit within the ceiling.
  always_comb begin
    coin_ok = (coin == 8'd1) || (coin == 8'd5) || (coin == 8'd10);
    sum     = {1'b0, balance} + {1'b0, coin};
    accept  = coin_ok && (sum <= 9'(MAX_BAL));
    b       = accept ? sum[7:0] : balance;
  end

  always_comb begin
    price = 8'd0;
    case (drink_choose)
      4'd1:    price = 8'(PRICE1);
      4'd2:    price = 8'(PRICE2);
      4'd3:    price = 8'(PRICE3);
      4'd4:    price = 8'(PRICE4);
      default: price = 8'd0;
    endcase
  end

  // Selection step operates on the post-coin credit b.
  always_comb begin
    txn             = '0;
    txn.balance     = b;
    txn.coin_reject = (coin != 8'd0) && !accept;
    if (drink_choose == 4'd0) begin
      txn.change_valid = 1'b1;
      txn.change       = b;
      txn.balance      = 8'd0;
    end else if (drink_choose <= 4'd4) begin
      if (b >= price) begin
        txn.dispense  = 1'b1;
        txn.drink_out = drink_choose;
        txn.balance   = b - price;
      end else begin
        txn.insufficient = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      balance      <= 8'd0;
      dispense     <= 1'b0;
      drink_out    <= 4'd0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      change       <= 8'd0;
      coin_reject  <= 1'b0;
    end else if (!en_machine) begin
      dispense     <= 1'b0;
      drink_out    <= 4'd0;
      insufficient <= 1'b0;
      change_valid <= 1'b0;
      change       <= 8'd0;
      coin_reject  <= 1'b0;
    end else begin
      balance      <= txn.balance;
      dispense     <= txn.dispense;
      drink_out    <= txn.drink_out;
      insufficient <= txn.insufficient;
      change_valid <= txn.change_valid;
      change       <= txn.change;
      coin_reject  <= txn.coin_reject;
    end
  end

  // Credit-tracking FSM; informational only, no output depends on it.
  always_comb begin
    state_nxt = state;
    if (en_machine) begin
      case (state)
        IDLE:    if (accept && txn.balance != 8'd0) state_nxt = CREDIT;
        CREDIT:  if (txn.balance == 8'd0)           state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

endmodule

// File: tb/tb_vending_machine_ctrl.sv
// Directed bench for vending_machine_ctrl: hand-computed expectations per scenario task.
module tb_vending_machine_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] coin = 8'd0;
  logic [3:0] drink_choose = 4'd15;
  logic       en_machine = 1'b0;
  logic [7:0] balance;
  logic       dispense;
  logic [3:0] drink_out;
  logic       insufficient;
  logic       change_valid;
  logic [7:0] change;
  logic       coin_reject;

  int vectors = 0;
  int errors  = 0;

  vending_machine_ctrl dut (
    .clk(clk), .rst(rst), .coin(coin), .drink_choose(drink_choose),
    .en_machine(en_machine), .balance(balance), .dispense(dispense),
    .drink_out(drink_out), .insufficient(insufficient),
    .change_valid(change_valid), .change(change), .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and land 1 time unit after the sampling edge.
  task automatic step(input logic [7:0] c, input logic [3:0] d, input logic e);
    coin = c; drink_choose = d; en_machine = e;
    @(posedge clk); #1;
    coin = 8'd0; drink_choose = 4'd15; en_machine = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(8'd0, 4'd15, 1'b1);
    step(8'd0, 4'd15, 1'b1);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(8'd10, 4'd0, 1'b1);
    step(8'd10, 4'd1, 1'b1);
    rst = 1'b0;
    vectors++;
    if (balance !== 8'd0) begin errors++; $display("FAIL reset_balance got %0d want 0", balance); end
    vectors++;
    if ({dispense, insufficient, change_valid, coin_reject} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses got %b want 0000", {dispense, insufficient, change_valid, coin_reject});
    end
    vectors++;
    if (drink_out !== 4'd0 || change !== 8'd0) begin
      errors++; $display("FAIL reset_data got drink_out=%0d change=%0d want 0 0", drink_out, change);
    end
  endtask

  task automatic test_purchase();
    step(8'd10, 4'd15, 1'b1);
    step(8'd10, 4'd15, 1'b1);
    step(8'd1,  4'd15, 1'b1);
    step(8'd5,  4'd15, 1'b1);
    vectors++;
    if (balance !== 8'd26) begin errors++; $display("FAIL buy_credit got %0d want 26", balance); end
    step(8'd0, 4'd2, 1'b1);
    vectors++;
    if (dispense !== 1'b1 || drink_out !== 4'd2 || balance !== 8'd11) begin
      errors++; $display("FAIL buy_drink2 got disp=%b drink=%0d bal=%0d want 1 2 11", dispense, drink_out, balance);
    end
    step(8'd0, 4'd15, 1'b1);
    vectors++;
    if (dispense !== 1'b0 || drink_out !== 4'd0 || balance !== 8'd11) begin
      errors++; $display("FAIL buy_pulse_clear got disp=%b drink=%0d bal=%0d want 0 0 11", dispense, drink_out, balance);
    end
    step(8'd0, 4'd0, 1'b1);
    vectors++;
    if (change_valid !== 1'b1 || change !== 8'd11 || balance !== 8'd0) begin
      errors++; $display("FAIL buy_change got cv=%b chg=%0d bal=%0d want 1 11 0", change_valid, change, balance);
    end
  endtask

  task automatic test_purchase_mixed();
    step(8'd5, 4'd15, 1'b1);
    step(8'd5, 4'd15, 1'b1);
    step(8'd1, 4'd15, 1'b1);
    step(8'd1, 4'd15, 1'b1);
    step(8'd10, 4'd15, 1'b1);
    vectors++;
    if (balance !== 8'd22) begin errors++; $display("FAIL mixed_credit got %0d want 22", balance); end
    step(8'd0, 4'd2, 1'b1);
    vectors++;
    if (dispense !== 1'b1 || balance !== 8'd7) begin
      errors++; $display("FAIL mixed_drink2 got disp=%b bal=%0d want 1 7", dispense, balance);
    end
    step(8'd0, 4'd0, 1'b1);
    vectors++;
    if (change_valid !== 1'b1 || change !== 8'd7 || balance !== 8'd0) begin
      errors++; $display("FAIL mixed_change got cv=%b chg=%0d bal=%0d want 1 7 0", change_valid, change, balance);
    end
  endtask

  task automatic test_insufficient();
    step(8'd10, 4'd15, 1'b1);
    step(8'd0, 4'd2, 1'b1);
    vectors++;
    if (insufficient !== 1'b1 || dispense !== 1'b0 || balance !== 8'd10) begin
      errors++; $display("FAIL insuf_flag got insuf=%b disp=%b bal=%0d want 1 0 10", insufficient, dispense, balance);
    end
    step(8'd10, 4'd15, 1'b1);
    vectors++;
    if (insufficient !== 1'b0 || balance !== 8'd20) begin
      errors++; $display("FAIL insuf_topup got insuf=%b bal=%0d want 0 20", insufficient, balance);
    end
    step(8'd0, 4'd2, 1'b1);
    vectors++;
    if (dispense !== 1'b1 || drink_out !== 4'd2 || balance !== 8'd5) begin
      errors++; $display("FAIL insuf_buy got disp=%b drink=%0d bal=%0d want 1 2 5", dispense, drink_out, balance);
    end
    step(8'd0, 4'd0, 1'b1);
  endtask

  task automatic test_reject_and_enable();
    step(8'd10, 4'd15, 1'b1);
    step(8'd5,  4'd15, 1'b1);
    step(8'd1,  4'd15, 1'b1);
    step(8'd1,  4'd15, 1'b1);
    step(8'd0,  4'd1,  1'b1);
    vectors++;
    if (dispense !== 1'b1 || drink_out !== 4'd1 || balance !== 8'd7) begin
      errors++; $display("FAIL rej_drink1 got disp=%b drink=%0d bal=%0d want 1 1 7", dispense, drink_out, balance);
    end
    step(8'd3, 4'd15, 1'b1);
    vectors++;
    if (coin_reject !== 1'b1 || balance !== 8'd7) begin
      errors++; $display("FAIL rej_coin3 got rej=%b bal=%0d want 1 7", coin_reject, balance);
    end
    step(8'd10, 4'd1, 1'b0);
    vectors++;
    if (coin_reject !== 1'b0 || dispense !== 1'b0 || balance !== 8'd7) begin
      errors++; $display("FAIL rej_disabled got rej=%b disp=%b bal=%0d want 0 0 7", coin_reject, dispense, balance);
    end
    // Coin and selection in the same cycle: 7+10=17 covers drink 1.
    step(8'd10, 4'd1, 1'b1);
    vectors++;
    if (dispense !== 1'b1 || balance !== 8'd7) begin
      errors++; $display("FAIL rej_coin_and_buy got disp=%b bal=%0d want 1 7", dispense, balance);
    end
    step(8'd0, 4'd0, 1'b1);
    step(8'd0, 4'd0, 1'b1);
    vectors++;
    if (change_valid !== 1'b1 || change !== 8'd0 || balance !== 8'd0) begin
      errors++; $display("FAIL zero_change got cv=%b chg=%0d bal=%0d want 1 0 0", change_valid, change, balance);
    end
    step(8'd10, 4'd15, 1'b1);
    step(8'd10, 4'd15, 1'b1);
    step(8'd5,  4'd4,  1'b1);
    vectors++;
    if (dispense !== 1'b1 || drink_out !== 4'd4 || balance !== 8'd0) begin
      errors++; $display("FAIL exact_drink4 got disp=%b drink=%0d bal=%0d want 1 4 0", dispense, drink_out, balance);
    end
  endtask

  task automatic test_ceiling_and_reset();
    for (int i = 0; i < 25; i++) step(8'd10, 4'd15, 1'b1);
    vectors++;
    if (balance !== 8'd250) begin errors++; $display("FAIL max_fill got %0d want 250", balance); end
    step(8'd10, 4'd15, 1'b1);
    vectors++;
    if (coin_reject !== 1'b1 || balance !== 8'd250) begin
      errors++; $display("FAIL max_over got rej=%b bal=%0d want 1 250", coin_reject, balance);
    end
    step(8'd5, 4'd15, 1'b1);
    vectors++;
    if (coin_reject !== 1'b0 || balance !== 8'd255) begin
      errors++; $display("FAIL max_exact got rej=%b bal=%0d want 0 255", coin_reject, balance);
    end
    step(8'd1, 4'd15, 1'b1);
    vectors++;
    if (coin_reject !== 1'b1 || balance !== 8'd255) begin
      errors++; $display("FAIL max_plus1 got rej=%b bal=%0d want 1 255", coin_reject, balance);
    end
    step(8'd0, 4'd0, 1'b1);
    step(8'd10, 4'd15, 1'b1);
    step(8'd5,  4'd15, 1'b1);
    step(8'd1,  4'd15, 1'b1);
    step(8'd1,  4'd15, 1'b1);
    vectors++;
    if (balance !== 8'd17) begin errors++; $display("FAIL pre_reset_credit got %0d want 17", balance); end
    rst = 1'b1;
    step(8'd0, 4'd0, 1'b1);
    rst = 1'b0;
    vectors++;
    if (balance !== 8'd0 || change_valid !== 1'b0 || change !== 8'd0) begin
      errors++; $display("FAIL reset_drops_credit got bal=%0d cv=%b chg=%0d want 0 0 0", balance, change_valid, change);
    end
  endtask

  initial begin
    test_reset();
    test_purchase();
    test_purchase_mixed();
    test_insufficient();
    do_reset();
    test_reject_and_enable();
    do_reset();
    test_ceiling_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
